// File: rtl/frame_packer.sv
// frame_packer: payload -> 16-bit big-endian word stream source for frame_detector.
// Each accepted payload is sent as
//   header(2) | {8'h00,chan} | data words (len) | CRC-16/XMODEM | trailer(2)
// and is followed by IDLE_GAP words of 0x0000 before the next header.
// Ports:
//   clk_in, rst_n          word clock, async active-low reset
//   pl_valid/pl_ready      payload handshake
//   pl_chan, pl_data,      payload fields, sampled on the accepting edge
//   pl_len, pl_crc_bad
//   data_out               word stream (0x0000 when idle)
//   frame_active           high for every header..trailer word
//   len_err                one-cycle pulse when a payload with len 0 or >8 is dropped
//   frame_cnt              frames emitted, wrapping
module frame_packer #(
  parameter logic [31:0] HEADER   = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER  = 32'h0E0E0E0E,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         pl_valid,
  output logic         pl_ready,
  input  logic [7:0]   pl_chan,
  input  logic [127:0] pl_data,
  input  logic [3:0]   pl_len,
  input  logic         pl_crc_bad,
  output logic [15:0]  data_out,
  output logic         frame_active,
  output logic         len_err,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_H, S_HDR_L, S_CHAN, S_DATA, S_CRC, S_TRL_H, S_TRL_L, S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
  localparam logic       GAP_ONE  = (IDLE_GAP == 1);

  state_t         state;
  logic [7:0]     chan_r;
  logic [127:0]   data_r;     // MSB-aligned payload, shifted left one word per DATA step
  logic [2:0]     left;       // data words still to send after the current one
  logic           crc_bad_r;
  logic [15:0]    crc_reg;
  logic [3:0]     gap_cnt;

  logic           accept;
  logic           len_ok;
  logic [3:0]     sh_words;
  logic [7:0]     shamt;

  assign accept   = pl_valid && pl_ready;
  assign len_ok   = (pl_len != 4'd0) && (pl_len <= 4'd8);
  // Left-align the right-justified payload so word 0 is always data_r[127:112].
  assign sh_words = 4'd8 - pl_len;
  assign shamt    = {sh_words, 4'b0000};

  // One CRC-16/XMODEM step over a full 16-bit word, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc ^ word;
    for (int i = 0; i < 16; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      data_out     <= '0;
      pl_ready     <= 1'b0;
      frame_active <= 1'b0;
      len_err      <= 1'b0;
      frame_cnt    <= '0;
      crc_reg      <= '0;
      chan_r       <= '0;
      data_r       <= '0;
      left         <= '0;
      crc_bad_r    <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      len_err <= 1'b0;
      // pl_ready is only high in IDLE or on the last GAP word, so an accept
      // can pre-empt either state and go straight to the header.
      if (accept) begin
        pl_ready  <= 1'b0;
        crc_reg   <= '0;
        chan_r    <= pl_chan;
        data_r    <= pl_data << shamt;
        left      <= 3'(pl_len - 4'd1);
        crc_bad_r <= pl_crc_bad;
        if (len_ok) begin
          state        <= S_HDR_H;
          data_out     <= HEADER[31:16];
          frame_active <= 1'b1;
        end else begin
          state        <= S_IDLE;
          data_out     <= '0;
          frame_active <= 1'b0;
          len_err      <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            pl_ready <= 1'b1;
            data_out <= '0;
          end
          S_HDR_H: begin
            state    <= S_HDR_L;
            data_out <= HEADER[15:0];
          end
          S_HDR_L: begin
            state    <= S_CHAN;
            data_out <= {8'h00, chan_r};
          end
          S_CHAN, S_DATA: begin
            if (state == S_DATA && left == 3'd0) begin
              state    <= S_CRC;
              data_out <= crc_bad_r ? ~crc_reg : crc_reg;
            end else begin
              state    <= S_DATA;
              data_out <= data_r[127:112];
              crc_reg  <= crc_step(crc_reg, data_r[127:112]);
              data_r   <= data_r << 16;
              if (state == S_DATA) left <= left - 3'd1;
            end
          end
          S_CRC: begin
            state    <= S_TRL_H;
            data_out <= TRAILER[31:16];
          end
          S_TRL_H: begin
            state    <= S_TRL_L;
            data_out <= TRAILER[15:0];
          end
          S_TRL_L: begin
            state        <= S_GAP;
            data_out     <= '0;
            frame_active <= 1'b0;
            frame_cnt    <= frame_cnt + 16'd1;
            gap_cnt      <= GAP_LAST;
            pl_ready     <= GAP_ONE;
          end
          S_GAP: begin
            data_out <= '0;
            if (gap_cnt == 4'd0) begin
              state    <= S_IDLE;
              pl_ready <= 1'b1;
            end else begin
              gap_cnt  <= gap_cnt - 4'd1;
              // raise ready while the last gap word is on the bus
              pl_ready <= (gap_cnt == 4'd1);
            end
          end
          default: begin
            state    <= S_IDLE;
            data_out <= '0;
          end
        endcase
      end
    end
  end

endmodule
